// File: rtl/mdu_pkg.sv
// Shared encodings and configuration helpers for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

  // Legal: even WIDTH >= 8, BITS_PER_CYCLE in {1,2,4,8} dividing WIDTH.
  function automatic bit mdu_cfg_legal(input int unsigned width, input int unsigned bpc);
    return (width >= 8) && (width % 2 == 0) &&
           (bpc == 1 || bpc == 2 || bpc == 4 || bpc == 8) && (width % bpc == 0);
  endfunction

  function automatic logic mdu_is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_signed(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide step: shift in a dividend bit, subtract divisor if it fits.
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next_c,
  output logic             q_bit_c
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor keeps the trial difference within WIDTH bits, so bit WIDTH is the borrow.
  assign shifted    = {rem, dividend_bit};
  assign diff       = shifted - {1'b0, divisor};
  assign q_bit_c    = ~diff[WIDTH];
  assign rem_next_c = q_bit_c ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Signed ops run on magnitudes; signs are reapplied in FIX.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if (!mdu_cfg_legal(WIDTH, BITS_PER_CYCLE)) begin : g_bad_cfg
    $error("mult_div_unit: illegal WIDTH/BITS_PER_CYCLE combination");
  end

  mdu_state_e       state;
  mdu_op_e          op_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opnd;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc;    // product high half or partial remainder
  logic [WIDTH-1:0] sh;     // multiplier / dividend, shifted out as the result fills in
  logic             neg_lo;
  logic             neg_hi;
  logic             dz;

  // Operand capture
  mdu_op_e          op_c;
  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;

  assign op_c    = mdu_op_e'(op);
  assign a_neg_c = mdu_is_signed(op_c) & a[WIDTH-1];
  assign b_neg_c = mdu_is_signed(op_c) & b[WIDTH-1];
  assign a_mag_c = a_neg_c ? -a : a;
  assign b_mag_c = b_neg_c ? -b : b;

  // Shift-add multiply: BITS_PER_CYCLE iterations of {acc, sh} >>= 1 with conditional add
  logic [WIDTH-1:0] mul_acc_c;
  logic [WIDTH-1:0] mul_sh_c;
  logic [WIDTH:0]   mul_sum_c;

  always_comb begin
    mul_acc_c = acc;
    mul_sh_c  = sh;
    mul_sum_c = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      mul_sum_c = {1'b0, mul_acc_c} + (mul_sh_c[0] ? {1'b0, opnd} : '0);
      mul_acc_c = mul_sum_c[WIDTH:1];
      mul_sh_c  = {mul_sum_c[0], mul_sh_c[WIDTH-1:1]};
    end
  end

  // Restoring divide chain; the first step produces the most significant new quotient bit
  logic [BITS_PER_CYCLE:0][WIDTH-1:0] rem_chain;
  logic [BITS_PER_CYCLE-1:0]          q_new;
  logic [WIDTH-1:0]                   div_sh_c;

  assign rem_chain[0] = acc;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_div
    mdu_div_step #(.WIDTH(WIDTH)) u_step (
      .rem          (rem_chain[i]),
      .dividend_bit (sh[WIDTH-1-i]),
      .divisor      (opnd),
      .rem_next_c   (rem_chain[i+1]),
      .q_bit_c      (q_new[BITS_PER_CYCLE-1-i])
    );
  end

  assign div_sh_c = (sh << BITS_PER_CYCLE) | WIDTH'(q_new);

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   quo_c;
  logic [WIDTH-1:0]   rem_c;

  assign prod_c = neg_lo ? -{acc, sh} : {acc, sh};
  assign quo_c  = dz ? '1 : (neg_lo ? -sh : sh);
  assign rem_c  = neg_hi ? -acc : acc;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      op_q        <= MDU_MULT;
      cnt         <= '0;
      opnd        <= '0;
      acc         <= '0;
      sh          <= '0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !flush) begin
            state  <= CALC;
            busy   <= 1'b1;
            op_q   <= op_c;
            cnt    <= '0;
            acc    <= '0;
            neg_lo <= a_neg_c ^ b_neg_c;
            if (mdu_is_div(op_c)) begin
              sh     <= a_mag_c;
              opnd   <= b_mag_c;
              neg_hi <= a_neg_c;
              dz     <= (b == '0);
            end else begin
              sh     <= b_mag_c;
              opnd   <= a_mag_c;
              neg_hi <= 1'b0;
              dz     <= 1'b0;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (mdu_is_div(op_q)) begin
              acc <= rem_chain[BITS_PER_CYCLE];
              sh  <= div_sh_c;
            end else begin
              acc <= mul_acc_c;
              sh  <= mul_sh_c;
            end
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            if (mdu_is_div(op_q)) begin
              hi          <= rem_c;
              lo          <= quo_c;
              div_by_zero <= dz;
            end else begin
              {hi, lo} <= prod_c;
            end
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised, multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits beside the single-cycle ALU in the execute stage; serves mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Uses iterative shift-add and restoring-divide at a configurable number of bits per cycle.
- Uses a start/busy/done handshake so the controller can stall dependent instructions.

Parameters:
WIDTH, 32, operand and HI/LO width; must be even and >= 8
BITS_PER_CYCLE, 1, iteration bits retired per clock; must divide WIDTH (legal: 1, 2, 4, 8)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
start  in  1  launch operation; sampled only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  in  WIDTH  rs operand (multiplicand / dividend)
b  in  WIDTH  rt operand (multiplier / divisor)
flush  in  1  abort in-flight operation (pipeline exception)
hi_we  in  1  mthi write enable
lo_we  in  1  mtlo write enable
wdata  in  WIDTH  mthi/mtlo data
busy  out  1  operation in flight
done  out  1  one-cycle pulse; HI/LO are valid
div_by_zero  out  1  pulses with done when a DIV/DIVU had b == 0
hi  out  WIDTH  HI register (mfhi source)
lo  out  WIDTH  LO register (mflo source)

Behaviour:
- Reset: all outputs and registers go to defined values.
  - hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0, state = IDLE.
  - Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, CALC, FIX. N = WIDTH / BITS_PER_CYCLE.
- IDLE + start at edge k:
  - Latch op.
  - For signed ops, latch the magnitudes of a and b plus the result signs.
  - Clear the iteration counter; go to CALC.
- CALC, edges k+1 .. k+N: retire BITS_PER_CYCLE bits per edge. After edge k+N, go to FIX.
- FIX, edge k+N+1:
  - Apply sign correction and write hi/lo.
  - Raise done (and div_by_zero if applicable) for exactly one cycle.
  - Return to IDLE.
  - Default latency: 33 edges after start; done is visible in cycle k+N+2.
- busy = (state != IDLE). busy falls in the same cycle done rises.
- Multiply results:
  - {hi, lo} = full 2*WIDTH-bit product.
  - MULT is two's-complement signed; MULTU is unsigned.
- Divide results:
  - lo = quotient, truncated toward zero.
  - hi = remainder, with the sign of the dividend.
  - Signed MIN / -1 yields lo = MIN, hi = 0, with no flag.
- Divide by zero:
  - lo = all ones, hi = a.
  - div_by_zero pulses with done.
  - Same latency as any other divide.
- start while busy is ignored; no queuing.
- hi_we/lo_we:
  - Accepted only in IDLE; take effect at the next edge. Dropped while busy.
  - If start and hi_we/lo_we are asserted in the same IDLE cycle, the write applies; the later FIX result then overwrites it.
- flush:
  - In CALC/FIX, return to IDLE at the next edge. hi/lo unchanged; no done pulse.
  - flush has priority over FIX completion.
  - flush together with start in IDLE: start is ignored.
- hi/lo change only on FIX, on an accepted hi_we/lo_we, or on reset.
- Operands a and b need not be held after start.

Decomposition:
- Package mdu_pkg holds:
  - op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU
  - state enum IDLE, CALC, FIX
  - a width-checking function for the legality of BITS_PER_CYCLE
- Sub-module mdu_div_step: combinational single-bit restoring-divide step (partial remainder, divisor -> next remainder, quotient bit). It is instantiated BITS_PER_CYCLE times in a generate chain.
- The multiply step is inline shift-add.

Test Plan:
- MULT a=FFFFFFFF, b=00000002 -> hi=FFFFFFFF, lo=FFFFFFFE; done exactly 33 edges after start; busy high for 33 cycles.
- MULTU a=FFFFFFFF, b=00000002 -> hi=00000001, lo=FFFFFFFE. DIVU a=00000064, b=00000007 -> lo=0000000E, hi=00000002.
- DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000, div_by_zero=0.
- DIV a=12345678, b=0 -> lo=FFFFFFFF, hi=12345678, div_by_zero=1 for one cycle concurrent with done.
- Mid-op events:
  - Start MULT, assert flush at CALC cycle 10 -> hi/lo keep prior values, no done, busy=0 next cycle.
  - start/hi_we while busy -> ignored.
  - reset low mid-CALC -> all outputs 0.
- With WIDTH=32, BITS_PER_CYCLE=4: MULTU 0000FFFF*0000FFFF -> hi=0, lo=FFFE0001, done 9 edges after start. Also run 1000 random ops per op code against a reference model.
